qft_pipeline_scheduler: RTL and testbench

- Admission and sequencing controller for the fixed-latency pipelined QFT datapath (gate stages ending in the swap stage); the datapath itself has no stall.
- Accepts state-vector requests over valid/ready and launches them into the datapath.
- Tracks in-flight vectors with a valid/tag shift register and manages write/read pointers of an external output buffer.
- Admission is credit-based, so results are never dropped when the consumer back-pressures.

---
 rtl/qft_pipeline_scheduler.sv | 150 +++++++++++++++
 tb/tb_qft_pipeline_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qft_pipeline_scheduler.sv
// Admission and sequencing controller for the fixed-latency QFT datapath.
// Credits cover both in-flight vectors and buffered results, so no result is ever dropped.
module qft_pipeline_scheduler #(
    parameter int PIPE_LATENCY = 6,
    parameter int OUT_DEPTH    = 4,
    parameter int ADDR_W       = 2,
    parameter int TAG_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              dp_launch,
    output logic              buf_wr_en,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic [ADDR_W-1:0] buf_rd_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TAG_W-1:0]  out_tag,
    input  logic              flush,
    output logic              busy,
    output logic [ADDR_W:0]   inflight_cnt,
    output logic [15:0]       done_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam logic [ADDR_W+1:0] DEPTH_C = (ADDR_W + 2)'(OUT_DEPTH);

    state_t             state_q, state_d;
    logic [PIPE_LATENCY-1:0] vld_q, vld_d;
    logic [TAG_W-1:0]   tag_pipe_q [PIPE_LATENCY];
    logic [TAG_W-1:0]   tag_pipe_d [PIPE_LATENCY];
    logic [TAG_W-1:0]   tag_mem_q  [OUT_DEPTH];
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]    occ_q, occ_d;
    logic [ADDR_W:0]    inflight_q, inflight_d;
    logic [15:0]        done_q, done_d;

    logic               run_st;
    logic               accept;
    logic               pop;
    logic [ADDR_W+1:0]  credit_used;

    // Credit check uses registered counts only; a pop frees credit one cycle later.
    always_comb begin
        run_st      = (state_q == ST_RUN);
        credit_used = {1'b0, inflight_q} + {1'b0, occ_q};
        in_ready    = ~rst & run_st & ~flush & (credit_used < DEPTH_C);
        accept      = in_valid & in_ready;
        buf_wr_en   = ~rst & vld_q[PIPE_LATENCY-1];
        out_valid   = ~rst & run_st & ~flush & (occ_q != '0);
        pop         = out_valid & out_ready;
    end

    assign dp_launch    = accept;
    assign buf_wr_addr  = wr_ptr_q;
    assign buf_rd_addr  = rd_ptr_q;
    assign out_tag      = tag_mem_q[rd_ptr_q];
    assign inflight_cnt = inflight_q;
    assign done_cnt     = done_q;
    assign busy         = ~run_st | (inflight_q != '0) | (occ_q != '0);

    // Valid/tag shift register mirroring the datapath stages.
    assign vld_d[0]      = accept;
    assign tag_pipe_d[0] = in_tag;

    genvar gi;
    generate
        for (gi = 1; gi < PIPE_LATENCY; gi++) begin : g_stage
            assign vld_d[gi]      = vld_q[gi-1];
            assign tag_pipe_d[gi] = tag_pipe_q[gi-1];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q + {{ADDR_W{1'b0}}, buf_wr_en} - {{ADDR_W{1'b0}}, pop};
        inflight_d = inflight_q + {{ADDR_W{1'b0}}, accept} - {{ADDR_W{1'b0}}, buf_wr_en};
        done_d     = done_q;
        if (buf_wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            done_d   = done_q + 16'd1;
        end
        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (inflight_q == '0) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d  = ST_RUN;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                occ_d    = '0;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            vld_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            inflight_q <= '0;
            done_q     <= '0;
        end else begin
            state_q    <= state_d;
            vld_q      <= vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

    // Tag data needs no reset: the vld bits and occupancy decide when it is meaningful.
    always_ff @(posedge clk) begin
        tag_pipe_q <= tag_pipe_d;
    end

    always_ff @(posedge clk) begin
        if (buf_wr_en) begin
            tag_mem_q[wr_ptr_q] <= tag_pipe_q[PIPE_LATENCY-1];
        end
    end

endmodule

// File: tb/tb_qft_pipeline_scheduler.sv
// Scoreboard bench for qft_pipeline_scheduler: a queue-based reference model predicts
// admission, write timing, delivery order and counters from the acceptance history.
module tb_qft_pipeline_scheduler;

    localparam int PL    = 6;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int TW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] in_tag;
    logic          dp_launch;
    logic          buf_wr_en;
    logic [AW-1:0] buf_wr_addr;
    logic [AW-1:0] buf_rd_addr;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] out_tag;
    logic          flush;
    logic          busy;
    logic [AW:0]   inflight_cnt;
    logic [15:0]   done_cnt;

    qft_pipeline_scheduler #(
        .PIPE_LATENCY (PL),
        .OUT_DEPTH    (DEPTH),
        .ADDR_W       (AW),
        .TAG_W        (TW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_tag       (in_tag),
        .dp_launch    (dp_launch),
        .buf_wr_en    (buf_wr_en),
        .buf_wr_addr  (buf_wr_addr),
        .buf_rd_addr  (buf_rd_addr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_tag      (out_tag),
        .flush        (flush),
        .busy         (busy),
        .inflight_cnt (inflight_cnt),
        .done_cnt     (done_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  n_checks = 0;
    int  n_err    = 0;
    bit  verbose  = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [TW-1:0] tag;
        int            wcyc;
    } ent_t;

    ent_t          acc_q[$];   // accepted, not yet written: tag and cycle it must be written
    logic [TW-1:0] buf_q[$];   // written, not yet delivered, in acceptance order
    int            wr_idx    = 0;
    int            rd_idx    = 0;
    int            done_m    = 0;
    int            run_from  = 0;
    int            clear_cyc = -1;
    bit            started   = 1'b0;

    always @(negedge clk) begin : monitor
        bit   run_ok, e_ready, e_wr, e_ov;
        int   outst, last;
        ent_t e;
        if (rst) begin
            started = 1'b1;
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_buf_wr_en", buf_wr_en, 0);
            chk("rst_dp_launch", dp_launch, 0);
            acc_q.delete();
            buf_q.delete();
            wr_idx    = 0;
            rd_idx    = 0;
            done_m    = 0;
            run_from  = cyc + 1;
            clear_cyc = -1;
        end else if (started) begin
            run_ok  = (cyc >= run_from);
            outst   = acc_q.size() + buf_q.size();
            e_ready = run_ok && !flush && (outst < DEPTH);
            e_wr    = (acc_q.size() > 0) && (acc_q[0].wcyc == cyc);
            e_ov    = run_ok && !flush && (buf_q.size() > 0);

            chk("in_ready", in_ready, e_ready);
            chk("dp_launch", dp_launch, in_valid && e_ready);
            chk("buf_wr_en", buf_wr_en, e_wr);
            chk("out_valid", out_valid, e_ov);
            chk("busy", busy, (!run_ok || outst != 0));
            chk("inflight_cnt", inflight_cnt, acc_q.size());
            chk("done_cnt", done_cnt, done_m % 65536);
            chk("occ_bound", (dut.occ_q <= DEPTH), 1);
            if (e_wr) chk("buf_wr_addr", buf_wr_addr, wr_idx % DEPTH);
            if (e_ov) begin
                chk("buf_rd_addr", buf_rd_addr, rd_idx % DEPTH);
                chk("out_tag", out_tag, buf_q[0]);
            end

            // Issue side: every acceptance pushes its expected write slot.
            if (in_valid && e_ready) begin
                e.tag  = in_tag;
                e.wcyc = cyc + PL;
                acc_q.push_back(e);
            end
            if (e_ov && out_ready) begin
                if (verbose) $display("pop tag=%02h done=%0d cycle=%0d", buf_q[0], done_m + 1, cyc);
                void'(buf_q.pop_front());
                rd_idx++;
                done_m++;
            end
            if (e_wr) begin
                buf_q.push_back(acc_q[0].tag);
                void'(acc_q.pop_front());
                wr_idx++;
            end
            // Flush: drain lasts until the cycle after the last pending write, then one clear cycle.
            if (flush && run_ok) begin
                last = cyc;
                if (acc_q.size() > 0) last = acc_q[$].wcyc;
                clear_cyc = last + 2;
                run_from  = last + 3;
            end
            if (cyc == clear_cyc) begin
                buf_q.delete();
                wr_idx = 0;
                rd_idx = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    bit s_acc, s_wr, s_ov;

    task automatic tick();
        @(negedge clk);
        s_acc = in_valid && in_ready;
        s_wr  = buf_wr_en;
        s_ov  = out_valid;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int wr_at, ov_at, n_acc, tag_n;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_tag = '0; out_ready = 1'b0; flush = 1'b0;
        idle(2);
        rst = 1'b0;

        // Single request latency
        out_ready = 1'b1; in_valid = 1'b1; in_tag = 8'h11;
        tick();
        chk("t1_accept", s_acc, 1);
        in_valid = 1'b0; wr_at = -1; ov_at = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (s_wr && wr_at < 0) wr_at = k;
            if (s_ov && ov_at < 0) ov_at = k;
        end
        chk("t1_wr_latency", wr_at, PL);
        chk("t1_ov_latency", ov_at, PL + 1);
        chk("t1_done", done_cnt, 1);
        chk("t1_busy", busy, 0);

        // Back-pressure: credit limits acceptance to DEPTH vectors
        apply_reset();
        out_ready = 1'b0; in_valid = 1'b1; tag_n = 1; in_tag = 8'd1; n_acc = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (s_acc) begin
                n_acc++; tag_n++;
                in_tag = tag_n[TW-1:0];
            end
        end
        chk("t2_accepted_blocked", n_acc, DEPTH);
        out_ready = 1'b1;
        for (int k = 0; k < 80 && in_valid; k++) begin
            tick();
            if (s_acc) begin
                n_acc++; tag_n++;
                in_tag = tag_n[TW-1:0];
                if (tag_n > 2 * DEPTH) in_valid = 1'b0;
            end
        end
        chk("t2_accepted_all", n_acc, 2 * DEPTH);
        in_valid = 1'b0;
        idle(20);

        // Flush with one buffered and two in flight
        apply_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_tag = 8'hA0; tick();
        in_valid = 1'b0; idle(8);
        in_valid = 1'b1; in_tag = 8'hB0; tick();
        in_tag = 8'hC0; tick();
        in_valid = 1'b0; flush = 1'b1; tick();
        chk("t4_flush_no_pop", s_ov, 0);
        flush = 1'b0;
        idle(15);
        chk("t4_busy", busy, 0);
        chk("t4_done", done_cnt, 0);
        chk("t4_inflight", inflight_cnt, 0);
        out_ready = 1'b1;
        idle(4);

        // Reset with three in flight
        apply_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_tag = 8'(k + 8'h50);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        idle(10);
        chk("t5_done", done_cnt, 0);
        chk("t5_busy", busy, 0);
        chk("t5_inflight", inflight_cnt, 0);

        // Randomized traffic with occasional flush and reset
        apply_reset();
        s_acc = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if (s_acc || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_tag   = TW'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 149) == 0);
            rst       = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        idle(30);

        // Long stream: full throughput, pointer and done_cnt wrap
        apply_reset();
        verbose = 1'b0; out_ready = 1'b1; in_valid = 1'b1; n_acc = 0;
        for (int k = 0; k < 70000; k++) begin
            in_tag = k[TW-1:0];
            tick();
            if (s_acc) n_acc++;
        end
        in_valid = 1'b0;
        idle(20);
        chk("t6_accepted", n_acc, 70000);
        chk("t6_done_wrap", done_cnt, 4464);
        chk("t6_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
